mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one fixed-latency unified memory port between the CPU instruction-fetch side (i_*) and the data-access side (d_*).
- Sits between the cpu top's i/d memory interfaces and a single memory model.
- Grants one requester at a time and sequences the memory access with a latency counter.
- Returns read data and a one-cycle acknowledge to the granted side.

Parameters:
- WORD_SIZE, 16, data and address width.
- LATENCY, 2, cycles m_readM/m_writeM are held per access; legal range 1 or more.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous reset, active-high (1 = reset asserted), despite the legacy name.
- i_req_read  in  1  instruction read request; level-held until i_ack.
- i_address  in  WORD_SIZE  instruction address; stable while i_req_read is high.
- i_rdata  out  WORD_SIZE  registered instruction read data.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in this cycle.
- d_req_read  in  1  data read request; level-held until d_ack.
- d_req_write  in  1  data write request; level-held until d_ack.
- d_address  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  write data.
- d_rdata  out  WORD_SIZE  registered data read result.
- d_ack  out  1  one-cycle completion pulse.
- m_readM  out  1  memory read strobe.
- m_writeM  out  1  memory write strobe.
- m_address  out  WORD_SIZE  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data; valid in the last strobe cycle.
- busy  out  1  high in BUSY and DONE states.

Behaviour:
- Reset: state IDLE, counter 0, every output 0 (including i_rdata and d_rdata). Asserting reset mid-access aborts it: strobes drop immediately and no ack is produced.
- IDLE:
  - If d_req_write or d_req_read is high, grant D.
  - Otherwise, if i_req_read is high, grant I.
  - Otherwise stay in IDLE.
  - On a grant: latch address, wdata, op and grant source into registers; load counter with LATENCY-1; go to BUSY.
- BUSY:
  - m_* are driven from the latched registers; the strobe is high for exactly LATENCY cycles.
  - Counter decrements each cycle.
  - When the counter is 0: on a read, capture m_rdata into the granted side's rdata register; go to DONE.
- DONE:
  - Strobes are 0.
  - Pulse the granted side's ack for one cycle.
  - Always go to IDLE. This dead cycle lets the requester drop its request.
- Timing: a request first high in cycle 0 gets strobes in cycles 1..LATENCY and ack in cycle LATENCY+1. The earliest next grant is in cycle LATENCY+2.
- d_req_read and d_req_write both high: treated as a write; a simulation-only assertion flags it.
- A request dropped mid-access: the access completes and the ack is still pulsed.
- A write never changes d_rdata. The non-granted side's rdata and ack are unchanged.
- Inputs are ignored outside IDLE. Counter width is $clog2(LATENCY+1).

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both sides request in IDLE, grant the side not granted last (last-grant flag reset to I, so the first contended grant goes to D).
- Undefined: fixed D-over-I priority; no last-grant flag is synthesized.
- An uncontended request is granted identically in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, BUSY, DONE.
  - grant enum: GNT_I, GNT_D.
  - op enum: OP_RD, OP_WR.
- Sub-module mem_lat_counter (load, decrement, zero flag), parameterized by LATENCY; instantiated once.

Test Plan:
All scenarios use LATENCY=2.
1. i_req_read in cycle 0, i_address 0x0010, m_rdata 0xBEEF -> m_readM high cycles 1-2 with m_address 0x0010; i_ack in cycle 3; i_rdata 0xBEEF; busy high cycles 1-3.
2. i_req_read and d_req_read both high in cycle 0 (fixed priority), d 0x0020 returns 0x1111, i 0x0030 returns 0x2222 -> d_ack in cycle 3 with d_rdata 0x1111; i strobes in cycles 5-6; i_ack in cycle 7 with i_rdata 0x2222.
3. d_req_write, d_address 0x0042, d_wdata 0x1234 -> m_writeM high cycles 1-2 with m_wdata 0x1234; d_ack in cycle 3; d_rdata unchanged; m_readM stays 0.
4. reset_n asserted in cycle 2 of an i read -> m_readM 0 in the same cycle; no i_ack; IDLE after release; a fresh request completes normally.
5. d_req_read dropped in cycle 2 -> d_ack still pulses in cycle 3 with captured data.
6. Both requests held continuously for 4 grants -> fixed priority grants D,D,D,D; with MEM_ARB_ROUND_ROBIN_EN grants D,I,D,I.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter (mem_arbiter, mem_lat_counter).
// Build option MEM_ARB_ROUND_ROBIN_EN is consumed by mem_arbiter only.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {GNT_I, GNT_D} grant_t;
   typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/mem_lat_counter.sv
// Access latency counter: loads LATENCY-1 on grant, counts down to zero while busy.
module mem_lat_counter
   import mem_arb_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);
   localparam int CW = $clog2(LATENCY + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= CW'(LATENCY - 1);
      else if (dec && (cnt != '0))
         cnt <= cnt - CW'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data sides onto one fixed-latency memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention (default: D over I).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int LATENCY   = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req_read,
   input  logic [WORD_SIZE-1:0] i_address,
   output logic [WORD_SIZE-1:0] i_rdata,
   output logic                 i_ack,
   input  logic                 d_req_read,
   input  logic                 d_req_write,
   input  logic [WORD_SIZE-1:0] d_address,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_ack,
   output logic                 m_readM,
   output logic                 m_writeM,
   output logic [WORD_SIZE-1:0] m_address,
   output logic [WORD_SIZE-1:0] m_wdata,
   input  logic [WORD_SIZE-1:0] m_rdata,
   output logic                 busy
);
   state_t               state, state_nxt;
   grant_t               gnt_q, gnt_nxt;
   op_t                  op_q;
   logic [WORD_SIZE-1:0] addr_q, wdata_q;
   logic                 take, cnt_zero, d_any;

   assign d_any = d_req_read | d_req_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   grant_t last_q;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n)
         last_q <= GNT_I;
      else if (take)
         last_q <= gnt_nxt;
   end
`endif

   always_comb begin
      state_nxt = state;
      gnt_nxt   = GNT_D;
      take      = 1'b0;
      m_readM   = 1'b0;
      m_writeM  = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (d_any || i_req_read) begin
               take      = 1'b1;
               state_nxt = BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               if (d_any && i_req_read)
                  gnt_nxt = (last_q == GNT_D) ? GNT_I : GNT_D;
               else
                  gnt_nxt = d_any ? GNT_D : GNT_I;
`else
               gnt_nxt = d_any ? GNT_D : GNT_I;
`endif
            end
         end
         BUSY: begin
            busy     = 1'b1;
            m_readM  = (op_q == OP_RD);
            m_writeM = (op_q == OP_WR);
            if (cnt_zero)
               state_nxt = DONE;
         end
         DONE: begin
            // dead cycle: requester sees its ack and drops the request before re-arbitration
            busy      = 1'b1;
            i_ack     = (gnt_q == GNT_I);
            d_ack     = (gnt_q == GNT_D);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         gnt_q   <= GNT_I;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         if (take) begin
            gnt_q   <= gnt_nxt;
            op_q    <= ((gnt_nxt == GNT_D) && d_req_write) ? OP_WR : OP_RD;
            addr_q  <= (gnt_nxt == GNT_D) ? d_address : i_address;
            wdata_q <= d_wdata;
         end
         if ((state == BUSY) && cnt_zero && (op_q == OP_RD)) begin
            if (gnt_q == GNT_D)
               d_rdata <= m_rdata;
            else
               i_rdata <= m_rdata;
         end
      end
   end

   assign m_address = addr_q;
   assign m_wdata   = wdata_q;

   mem_lat_counter #(.LATENCY(LATENCY)) u_lat_counter (
      .clk  (clk),
      .rst  (reset_n),
      .load (take),
      .dec  (state == BUSY),
      .zero (cnt_zero)
   );

`ifndef SYNTHESIS
   a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset_n) !(d_req_read && d_req_write))
      else $error("mem_arbiter: d_req_read and d_req_write both high");
`endif
endmodule
